multicycle_controller: RTL and testbench

Moore-style control FSM for the multicycle MIPS datapath: one shared ALU and one unified instruction/data memory, with per-instruction sequencing replacing the single-cycle combinational control unit. Each instruction is stepped through fetch, decode, execute, memory and write-back states. The controller issues all datapath enables and selects, stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM with memory handshake, illegal flag and retire counter
// Outputs decode from the state register; only FETCH also looks at memReady to gate irWrite/pcWrite.
module multicycle_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opCode,
  input  logic [5:0]  funcCode,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        regWrite,
  output logic [1:0]  regDst,
  output logic [1:0]  memtoReg,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  opALU,
  output logic [1:0]  pcSource,
  output logic        illegal,
  output logic [31:0] instrCount
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC,
    R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a, FN_JR = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100, ALU_LUI = 3'b101, ALU_ORI = 3'b110;

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] count_q, count_d;
  logic        retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (memReady) state_d = DECODE;
      DECODE: begin
        case (opCode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE: begin
            case (funcCode)
              FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: state_d = R_EXEC;
              FN_JR:   state_d = JR;
              default: state_d = HALT;
            endcase
          end
          OP_ORI, OP_LUI: state_d = I_EXEC;
          OP_BEQ:  state_d = BRANCH;
          OP_J:    state_d = JUMP;
          OP_JAL:  state_d = JAL;
          default: state_d = HALT;
        endcase
      end
      MEM_ADDR: state_d = (opCode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: if (memReady) state_d = MEM_WB;
      MEM_WRITE: begin
        if (memReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      R_EXEC:   state_d = R_WB;
      I_EXEC:   state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == HALT);
  assign count_d   = count_q + {31'd0, retire};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 2'b00;
    memtoReg    = 2'b00;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    opALU       = ALU_ADD;
    pcSource    = 2'b00;
    case (state_q)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE:   aluSrcB = 2'b11;
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      MEM_WB: begin
        regWrite = 1'b1;
        memtoReg = 2'b01;
      end
      R_EXEC: begin
        aluSrcA = 1'b1;
        case (funcCode)
          FN_SUBU: opALU = ALU_SUB;
          FN_AND:  opALU = ALU_AND;
          FN_OR:   opALU = ALU_OR;
          FN_SLT:  opALU = ALU_SLT;
          default: opALU = ALU_ADD;
        endcase
      end
      R_WB: begin
        regWrite = 1'b1;
        regDst   = 2'b01;
      end
      I_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        opALU   = (opCode == OP_LUI) ? ALU_LUI : ALU_ORI;
      end
      I_WB:     regWrite = 1'b1;
      BRANCH: begin
        aluSrcA     = 1'b1;
        opALU       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      // PC already holds PC+4 from FETCH, so $31 gets the return address directly.
      JAL: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        regWrite = 1'b1;
        regDst   = 2'b10;
        memtoReg = 2'b10;
      end
      JR: begin
        pcWrite  = 1'b1;
        pcSource = 2'b11;
      end
      default: ;
    endcase
  end

  assign illegal    = illegal_q;
  assign instrCount = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven directed bench for multicycle_controller
// Each record is one clock cycle: inputs applied at negedge, outputs and counter checked 1ns later.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opCode = 6'd0;
  logic [5:0]  funcCode = 6'd0;
  logic        memReady = 1'b0;
  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regWrite;
  logic [1:0]  regDst, memtoReg, aluSrcB, pcSource;
  logic        aluSrcA, illegal;
  logic [2:0]  opALU;
  logic [31:0] instrCount;

  multicycle_controller dut (
    .clock(clock), .reset(reset), .opCode(opCode), .funcCode(funcCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite), .regDst(regDst),
    .memtoReg(memtoReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .opALU(opALU),
    .pcSource(pcSource), .illegal(illegal), .instrCount(instrCount)
  );

  always #5 clock = ~clock;

  logic [19:0] obs;
  assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regWrite,
                regDst, memtoReg, aluSrcA, aluSrcB, opALU, pcSource, illegal};

  function automatic logic [19:0] v(input logic pcw, pcwc, iord, mr, mw, irw, rw,
                                    input logic [1:0] rdst, mtr, input logic asa,
                                    input logic [1:0] asb, input logic [2:0] op,
                                    input logic [1:0] pcs, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, rw, rdst, mtr, asa, asb, op, pcs, ill};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [19:0] exp_out;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] run_cnt;
  int          checks = 0;
  int          errors = 0;

  logic [19:0] E_IDLE, E_FETCH, E_FETCHW, E_DEC, E_MADDR, E_MREAD, E_MWRITE, E_MWB;
  logic [19:0] E_RADD, E_RSUB, E_RAND, E_ROR, E_RSLT, E_RWB, E_IORI, E_ILUI, E_IWB;
  logic [19:0] E_BR, E_J, E_JAL, E_JR, E_HALT;

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                     input logic [19:0] e, input logic ret);
    vec_t r;
    r.op = op; r.fn = fn; r.rdy = rdy; r.exp_out = e; r.exp_cnt = run_cnt;
    tbl.push_back(r);
    if (ret) run_cnt = run_cnt + 32'd1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    @(negedge clock);
    opCode = op; funcCode = fn; memReady = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    E_IDLE   = '0;
    E_FETCH  = v(1,0,0,1,0,1,0, 2'b00,2'b00, 0,2'b01,3'b000,2'b00, 0);
    E_FETCHW = v(0,0,0,1,0,0,0, 2'b00,2'b00, 0,2'b01,3'b000,2'b00, 0);
    E_DEC    = v(0,0,0,0,0,0,0, 2'b00,2'b00, 0,2'b11,3'b000,2'b00, 0);
    E_MADDR  = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b10,3'b000,2'b00, 0);
    E_MREAD  = v(0,0,1,1,0,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b00, 0);
    E_MWRITE = v(0,0,1,0,1,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b00, 0);
    E_MWB    = v(0,0,0,0,0,0,1, 2'b00,2'b01, 0,2'b00,3'b000,2'b00, 0);
    E_RADD   = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b000,2'b00, 0);
    E_RSUB   = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b001,2'b00, 0);
    E_RAND   = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b010,2'b00, 0);
    E_ROR    = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b011,2'b00, 0);
    E_RSLT   = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b100,2'b00, 0);
    E_RWB    = v(0,0,0,0,0,0,1, 2'b01,2'b00, 0,2'b00,3'b000,2'b00, 0);
    E_IORI   = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b10,3'b110,2'b00, 0);
    E_ILUI   = v(0,0,0,0,0,0,0, 2'b00,2'b00, 1,2'b10,3'b101,2'b00, 0);
    E_IWB    = v(0,0,0,0,0,0,1, 2'b00,2'b00, 0,2'b00,3'b000,2'b00, 0);
    E_BR     = v(0,1,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b001,2'b01, 0);
    E_J      = v(1,0,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b10, 0);
    E_JAL    = v(1,0,0,0,0,0,1, 2'b10,2'b10, 0,2'b00,3'b000,2'b10, 0);
    E_JR     = v(1,0,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b11, 0);
    E_HALT   = v(0,0,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b00, 1);

    run_cnt = 32'd0;
    add(6'h00, 6'h21, 1, E_IDLE, 0);
    // addu: 4 cycles
    add(6'h00, 6'h21, 1, E_FETCH, 0); add(6'h00, 6'h21, 0, E_DEC, 0);
    add(6'h00, 6'h21, 0, E_RADD, 0);  add(6'h00, 6'h21, 1, E_RWB, 1);
    // lw with three wait cycles in MEM_READ: 8 cycles
    add(6'h23, 6'h00, 1, E_FETCH, 0); add(6'h23, 6'h00, 1, E_DEC, 0);
    add(6'h23, 6'h00, 0, E_MADDR, 0);
    add(6'h23, 6'h00, 0, E_MREAD, 0); add(6'h23, 6'h00, 0, E_MREAD, 0);
    add(6'h23, 6'h00, 0, E_MREAD, 0); add(6'h23, 6'h00, 1, E_MREAD, 0);
    add(6'h23, 6'h00, 1, E_MWB, 1);
    // sw: 4 cycles
    add(6'h2b, 6'h00, 1, E_FETCH, 0); add(6'h2b, 6'h00, 1, E_DEC, 0);
    add(6'h2b, 6'h00, 1, E_MADDR, 0); add(6'h2b, 6'h00, 1, E_MWRITE, 1);
    // subu with one FETCH wait
    add(6'h00, 6'h23, 0, E_FETCHW, 0); add(6'h00, 6'h23, 1, E_FETCH, 0);
    add(6'h00, 6'h23, 1, E_DEC, 0);    add(6'h00, 6'h23, 1, E_RSUB, 0);
    add(6'h00, 6'h23, 0, E_RWB, 1);
    add(6'h0d, 6'h00, 1, E_FETCH, 0); add(6'h0d, 6'h00, 1, E_DEC, 0);
    add(6'h0d, 6'h00, 1, E_IORI, 0);  add(6'h0d, 6'h00, 1, E_IWB, 1);
    add(6'h0f, 6'h00, 1, E_FETCH, 0); add(6'h0f, 6'h00, 0, E_DEC, 0);
    add(6'h0f, 6'h00, 0, E_ILUI, 0);  add(6'h0f, 6'h00, 0, E_IWB, 1);
    add(6'h00, 6'h24, 1, E_FETCH, 0); add(6'h00, 6'h24, 1, E_DEC, 0);
    add(6'h00, 6'h24, 1, E_RAND, 0);  add(6'h00, 6'h24, 1, E_RWB, 1);
    add(6'h00, 6'h25, 1, E_FETCH, 0); add(6'h00, 6'h25, 1, E_DEC, 0);
    add(6'h00, 6'h25, 1, E_ROR, 0);   add(6'h00, 6'h25, 1, E_RWB, 1);
    add(6'h00, 6'h2a, 1, E_FETCH, 0); add(6'h00, 6'h2a, 1, E_DEC, 0);
    add(6'h00, 6'h2a, 1, E_RSLT, 0);  add(6'h00, 6'h2a, 1, E_RWB, 1);
    // beq, jal, j, jr back to back: 3 cycles each
    add(6'h04, 6'h00, 1, E_FETCH, 0); add(6'h04, 6'h00, 1, E_DEC, 0); add(6'h04, 6'h00, 0, E_BR, 1);
    add(6'h03, 6'h00, 1, E_FETCH, 0); add(6'h03, 6'h00, 1, E_DEC, 0); add(6'h03, 6'h00, 1, E_JAL, 1);
    add(6'h02, 6'h00, 1, E_FETCH, 0); add(6'h02, 6'h00, 1, E_DEC, 0); add(6'h02, 6'h00, 1, E_J, 1);
    add(6'h00, 6'h08, 1, E_FETCH, 0); add(6'h00, 6'h08, 1, E_DEC, 0); add(6'h00, 6'h08, 1, E_JR, 1);
    add(6'h3f, 6'h00, 1, E_FETCH, 0); add(6'h3f, 6'h00, 1, E_DEC, 0);

    // reset asserted from time 0
    #2;
    chk("rst_out", 0, {12'd0, obs}, 32'd0);
    chk("rst_cnt", 0, instrCount, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clock);
      opCode = tbl[i].op; funcCode = tbl[i].fn; memReady = tbl[i].rdy;
      #1;
      chk("out", i, {12'd0, obs}, {12'd0, tbl[i].exp_out});
      chk("cnt", i, instrCount, tbl[i].exp_cnt);
    end

    // illegal opcode: HALT sticky for 20 cycles, counter frozen
    for (int i = 0; i < 20; i++) begin
      drive(6'h3f, 6'h00, i[0]);
      chk("halt_out", i, {12'd0, obs}, {12'd0, E_HALT});
      chk("halt_cnt", i, instrCount, 32'd13);
    end
    do_reset();
    chk("halt_clr_ill", 0, {31'd0, illegal}, 32'd0);
    chk("halt_clr_cnt", 0, instrCount, 32'd0);

    // counter wrap on a j
    force dut.count_q = 32'hFFFF_FFFF;
    drive(6'h02, 6'h00, 1);
    release dut.count_q;
    chk("wrap_pre", 0, instrCount, 32'hFFFF_FFFF);
    chk("wrap_fetch", 0, {12'd0, obs}, {12'd0, E_FETCH});
    drive(6'h02, 6'h00, 1);
    drive(6'h02, 6'h00, 1);
    chk("wrap_j", 0, {12'd0, obs}, {12'd0, E_J});
    chk("wrap_pre2", 0, instrCount, 32'hFFFF_FFFF);
    drive(6'h02, 6'h00, 1);
    chk("wrap_post", 0, instrCount, 32'd0);

    // reset during a stalled MEM_WRITE
    drive(6'h2b, 6'h00, 1);
    drive(6'h2b, 6'h00, 1);
    drive(6'h2b, 6'h00, 0);
    drive(6'h2b, 6'h00, 0);
    chk("sw_stall", 0, {12'd0, obs}, {12'd0, E_MWRITE});
    #1 reset = 1'b0;
    #1;
    chk("sw_abort_out", 0, {12'd0, obs}, 32'd0);
    chk("sw_abort_cnt", 0, instrCount, 32'd0);
    memReady = 1'b1;
    @(negedge clock);
    #1;
    chk("sw_abort_hold", 0, {12'd0, obs}, 32'd0);
    chk("sw_abort_cnt2", 0, instrCount, 32'd0);
    reset = 1'b1;
    drive(6'h00, 6'h21, 1);
    chk("restart_fetch", 0, {12'd0, obs}, {12'd0, E_FETCH});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
